// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - select codes and state encoding shared by the shift sequencer
package usr_pkg;

   localparam logic [2:0] SEL_HOLD  = 3'b000;
   localparam logic [2:0] SEL_SHR   = 3'b001;
   localparam logic [2:0] SEL_SHL   = 3'b010;
   localparam logic [2:0] SEL_ROTR  = 3'b011;
   localparam logic [2:0] SEL_ROTL  = 3'b100;
   localparam logic [2:0] SEL_SHR_X = 3'b101;
   localparam logic [2:0] SEL_SHL_X = 3'b110;
   localparam logic [2:0] SEL_LOAD  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/USR_4BIT.sv
// rtl/USR_4BIT.sv - 4-bit universal shift register driven by the sequencer
module USR_4BIT #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] data
);

   // Serial-in bit for the "load X" shifts comes from the matching end of parallel_in.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         data <= '0;
      end else begin
         case (select)
            3'b001:  data <= {1'b0, data[WIDTH-1:1]};
            3'b010:  data <= {data[WIDTH-2:0], 1'b0};
            3'b011:  data <= {data[0], data[WIDTH-1:1]};
            3'b100:  data <= {data[WIDTH-2:0], data[WIDTH-1]};
            3'b101:  data <= {parallel_in[WIDTH-1], data[WIDTH-1:1]};
            3'b110:  data <= {data[WIDTH-2:0], parallel_in[0]};
            3'b111:  data <= parallel_in;
            default: data <= data;
         endcase
      end
   end

endmodule

// File: rtl/usr_step_counter.sv
// rtl/usr_step_counter.sv - loadable shift-phase down-counter with last-step flag
module usr_step_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;

   // Decrement saturates at zero so a stray dec can never wrap the count.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/usr_shift_sequencer.sv
// rtl/usr_shift_sequencer.sv - command-driven load/shift/respond controller for one USR
module usr_shift_sequencer
   import usr_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [2:0]       usr_select,
   output logic [WIDTH-1:0] usr_parallel_in,
   input  logic [WIDTH-1:0] usr_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] data_q;
   logic             accept;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_last;

   assign accept = cmd_valid && (state == ST_IDLE);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state   <= ST_IDLE;
         op_q    <= SEL_HOLD;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= cmd_op;
            count_q <= cmd_count;
            data_q  <= cmd_data;
         end
      end
   end

   usr_step_counter #(.CNT_W(CNT_W)) u_step_counter (
      .clk      (clk),
      .clear    (clear),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (count_q),
      .last     (cnt_last)
   );

   always_comb begin
      state_nxt  = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      usr_select = SEL_HOLD;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            usr_select = SEL_LOAD;
            // A parallel-load op already finished in this cycle, so its count is moot.
            if ((count_q == '0) || (op_q == SEL_LOAD)) begin
               state_nxt = ST_RESP;
            end else begin
               state_nxt = ST_SHIFT;
               cnt_load  = 1'b1;
            end
         end
         ST_SHIFT: begin
            usr_select = op_q;
            cnt_dec    = 1'b1;
            if (cnt_last) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign usr_parallel_in = data_q;
   assign cmd_ready       = (state == ST_IDLE);
   assign busy            = (state != ST_IDLE);
   assign rsp_valid       = (state == ST_RESP);
   assign rsp_data        = rsp_valid ? usr_data : '0;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb/tb_usr_shift_sequencer.sv - scoreboard bench for usr_shift_sequencer with USR_4BIT
module tb_usr_shift_sequencer;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [2:0] cmd_count = 3'd0;
   logic [3:0] cmd_data = 4'd0;
   logic [2:0] usr_select;
   logic [3:0] usr_parallel_in;
   logic [3:0] usr_data;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_data;
   logic       busy;

   typedef struct {
      logic [3:0] data;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic prev_valid = 1'b0;

   usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk             (clk),
      .clear           (clear),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_count       (cmd_count),
      .cmd_data        (cmd_data),
      .usr_select      (usr_select),
      .usr_parallel_in (usr_parallel_in),
      .usr_data        (usr_data),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .busy            (busy)
   );

   USR_4BIT #(.WIDTH(4)) u_usr (
      .clk         (clk),
      .clear       (clear),
      .select      (usr_select),
      .parallel_in (usr_parallel_in),
      .data        (usr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: apply the operation count times to a 4-bit value using integer arithmetic.
   function automatic int ref_result(input int op, input int cnt, input int data);
      int v;
      v = data;
      if (op == 7 || cnt == 0) return data;
      for (int i = 0; i < cnt; i++) begin
         case (op)
            1: v = v / 2;
            2: v = (v * 2) % 16;
            3: v = v / 2 + (v % 2) * 8;
            4: v = (v * 2) % 16 + v / 8;
            5: v = v / 2 + (data / 8) * 8;
            6: v = (v * 2) % 16 + (data % 2);
            default: v = v;
         endcase
      end
      return v;
   endfunction

   // Monitor: every new response is popped from the scoreboard and checked for value and timing.
   always @(negedge clk) begin
      if (!clear) begin
         prev_valid <= 1'b0;
      end else begin
         if (!rsp_valid) check("rsp_data_idle_zero", int'(rsp_data), 0);
         if (rsp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_data", int'(rsp_data), int'(e.data));
               check("rsp_latency_cycle", cyc, e.cyc);
            end
         end
         prev_valid <= rsp_valid;
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!cmd_ready && t < 30) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_wait", int'(cmd_ready), 1);
   endtask

   task automatic do_cmd(input int op, input int cnt, input int data, input int hold);
      int         nshift;
      int         t;
      logic [3:0] held;
      wait_ready();
      cmd_op    = 3'(op);
      cmd_count = 3'(cnt);
      cmd_data  = 4'(data);
      cmd_valid = 1'b1;
      nshift    = (op == 7) ? 0 : cnt;
      exp_q.push_back('{data: 4'(ref_result(op, cnt, data)), cyc: cyc + 1 + nshift + 1});
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom_range(7));
      cmd_data  = 4'($urandom_range(15));
      rsp_ready = 1'($urandom_range(1));
      check("load_select", int'(usr_select), 7);
      check("load_cmd_ready", int'(cmd_ready), 0);
      check("load_busy", int'(busy), 1);
      for (int k = 0; k < nshift; k++) begin
         @(negedge clk);
         rsp_ready = 1'($urandom_range(1));
         check("shift_select", int'(usr_select), op);
      end
      rsp_ready = 1'b0;
      @(negedge clk);
      t = 0;
      while (!rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("rsp_valid_seen", int'(rsp_valid), 1);
      held = rsp_data;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         cmd_op    = 3'($urandom_range(7));
         cmd_count = 3'($urandom_range(7));
         @(negedge clk);
         check("resp_hold_select", int'(usr_select), 0);
         check("resp_hold_cmd_ready", int'(cmd_ready), 0);
         check("resp_hold_valid", int'(rsp_valid), 1);
         check("resp_hold_data", int'(rsp_data), int'(held));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("post_rsp_cmd_ready", int'(cmd_ready), 1);
      check("post_rsp_valid", int'(rsp_valid), 0);
      check("post_rsp_busy", int'(busy), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_select", int'(usr_select), 0);
      check("reset_pin", int'(usr_parallel_in), 0);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_rsp_data", int'(rsp_data), 0);
      check("reset_busy", int'(busy), 0);
      clear = 1'b1;
      @(negedge clk);
      check("reset_release_cmd_ready", int'(cmd_ready), 1);

      do_cmd(0, 0, 4'b1011, 0);
      do_cmd(1, 4, 4'b1111, 0);
      do_cmd(3, 1, 4'b1000, 0);
      do_cmd(4, 1, 4'b1000, 0);
      do_cmd(7, 5, 4'b0110, 0);
      do_cmd(2, 2, 4'b0011, 3);

      // Abort a shift-left command after its first shift edge.
      wait_ready();
      cmd_op = 3'd2; cmd_count = 3'd3; cmd_data = 4'b0101; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b0;
      #1;
      check("abort_select", int'(usr_select), 0);
      check("abort_pin", int'(usr_parallel_in), 0);
      check("abort_usr_data", int'(usr_data), 0);
      check("abort_rsp_valid", int'(rsp_valid), 0);
      check("abort_rsp_data", int'(rsp_data), 0);
      check("abort_busy", int'(busy), 0);
      @(negedge clk);
      clear = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("abort_no_rsp", int'(rsp_valid), 0);
      end
      check("abort_cmd_ready", int'(cmd_ready), 1);

      do_cmd(6, 3, 4'b0001, 1);
      do_cmd(5, 2, 4'b1000, 0);
      for (int i = 0; i < 60; i++) begin
         do_cmd(int'($urandom_range(7)), int'($urandom_range(7)),
                int'($urandom_range(15)), int'($urandom_range(3)));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
